// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan controller.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DEBOUNCE,
        PUSH,
        RELEASE
    } kp_state_e;

    localparam logic [3:0] COL_ALL = 4'b1111;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic onehot_valid(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // code = 4*row_index + col_index
    function automatic logic [3:0] compose_code(input logic [1:0] row_idx,
                                                input logic [1:0] col_idx);
        return {row_idx, col_idx};
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Show-ahead key-code queue; a push into a full queue succeeds only with a same-cycle pop.
module keypad_fifo
    import keypad_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] din,
    output logic       full,
    output logic       empty,
    output logic [3:0] dout
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [3:0]    last_q;
    logic          do_pop;
    logic          wr_en;

    assign full   = (count == (AW+1)'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign wr_en  = push && (!full || do_pop);
    // Once drained, the output keeps showing the most recently popped code.
    assign dout   = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= 4'd0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({wr_en, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 hex keypad sequencer: idle detect, column scan, debounce, release wait, code queue.
// state    | meaning
// IDLE     | all columns driven, waiting for any row activity
// SCAN     | one column driven for SCAN_DIV cycles, rows sampled on the last one
// DEBOUNCE | latched column held until the latched row is stable long enough
// PUSH     | key code written to the queue (dropped with overflow when full)
// RELEASE  | all columns driven until the rows stay quiet long enough
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overflow,
    input  logic       clear_ovf,
    output logic       busy
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] DEB_MAX    = BW'(DEBOUNCE_CYCLES);

    kp_state_e     state;
    kp_state_e     state_nxt;
    logic [3:0]    row_m;
    logic [3:0]    row_s;
    logic [3:0]    row_lat;
    logic [1:0]    col_idx;
    logic [DW-1:0] dwell_cnt;
    logic [BW-1:0] deb_cnt;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          dwell_end;

    assign dwell_end = (dwell_cnt == DWELL_LAST);
    assign pop       = key_valid && key_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_m <= 4'b0000;
            row_s <= 4'b0000;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (row_s != 4'b0000) state_nxt = SCAN;
            end
            SCAN: begin
                if (dwell_end) begin
                    if (onehot_valid(row_s))     state_nxt = DEBOUNCE;
                    else if (row_s != 4'b0000)   state_nxt = RELEASE;
                    else if (col_idx == 2'd3)    state_nxt = IDLE;
                end
            end
            DEBOUNCE: begin
                if (row_s != row_lat)          state_nxt = IDLE;
                else if (deb_cnt >= DEB_LAST)  state_nxt = PUSH;
            end
            PUSH: state_nxt = RELEASE;
            RELEASE: begin
                if (row_s == 4'b0000 && deb_cnt >= DEB_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        col  = COL_ALL;
        busy = (state != IDLE);
        push = (state == PUSH);
        unique case (state)
            SCAN, DEBOUNCE, PUSH: col = 4'b0001 << col_idx;
            default:              col = COL_ALL;
        endcase
    end

    // Counters saturate at their maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            col_idx   <= 2'd0;
            row_lat   <= 4'b0000;
        end else begin
            unique case (state)
                IDLE: begin
                    dwell_cnt <= '0;
                    deb_cnt   <= '0;
                    col_idx   <= 2'd0;
                end
                SCAN: begin
                    if (dwell_end) begin
                        dwell_cnt <= '0;
                        deb_cnt   <= '0;
                        if (onehot_valid(row_s)) row_lat <= row_s;
                        if (row_s == 4'b0000 && col_idx != 2'd3) col_idx <= col_idx + 2'd1;
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (row_s == row_lat && deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + 1'b1;
                end
                PUSH: deb_cnt <= '0;
                RELEASE: begin
                    if (row_s != 4'b0000)      deb_cnt <= '0;
                    else if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + 1'b1;
                end
                default: deb_cnt <= '0;
            endcase
        end
    end

    // A drop sets the flag even when clear_ovf is asserted in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)                               overflow <= 1'b0;
        else if (push && fifo_full && !pop)    overflow <= 1'b1;
        else if (clear_ovf)                    overflow <= 1'b0;
    end

    keypad_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (compose_code(onehot_to_idx(row_lat), col_idx)),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (key_code)
    );

    assign key_valid = !fifo_empty;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model plus a queue-based reference of expected codes.
module tb_keypad_scan_ctrl;

    localparam int S     = 4;
    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int LAT_BOUND = 2 + 1 + 4*S + D + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        overflow;
    logic        clear_ovf;
    logic        busy;
    logic [15:0] pressed;

    int total = 0;
    int bad   = 0;
    int q[$];
    bit m_ovf;

    always #5 clk = ~clk;

    // Key (r,c) shorts column c onto row r.
    always_comb begin
        row = 4'b0000;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4*r + c] && col[c]) row[r] = 1'b1;
    end

    keypad_scan_ctrl #(
        .SCAN_DIV(S), .DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .overflow(overflow),
        .clear_ovf(clear_ovf), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic model_push(input int code);
        if (q.size() < DEPTH) q.push_back(code);
        else                  m_ovf = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid"}, key_valid, (q.size() != 0));
        check({tag, "_ovf"}, overflow, m_ovf);
        if (q.size() != 0) check({tag, "_code"}, key_code, q[0]);
    endtask

    task automatic press(input int code, input int hold);
        pressed = 16'h0000;
        pressed[code] = 1'b1;
        cyc(hold);
        pressed = 16'h0000;
        cyc(4);
        wait_idle("press");
    endtask

    task automatic press_model(input int code);
        press(code, 40);
        model_push(code);
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_pvalid"}, key_valid, 1);
        check({tag, "_pcode"}, key_code, q[0]);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        void'(q.pop_front());
    endtask

    // Press a key and drive pop/clear exactly during the cycle the code is written.
    task automatic press_timed(input int code, input bit do_pop, input bit do_clr);
        logic [3:0] tgt;
        int n = 0;
        bit was_full;
        tgt = 4'b0001 << (code % 4);
        pressed = 16'h0000;
        pressed[code] = 1'b1;
        while (col !== tgt && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timed_col_reached", col, tgt);
        cyc(S + D);
        if (do_pop) check("timed_head", key_code, q[0]);
        key_ready = do_pop;
        clear_ovf = do_clr;
        @(negedge clk);
        key_ready = 1'b0;
        clear_ovf = 1'b0;
        was_full = (q.size() == DEPTH);
        if (do_pop && q.size() != 0) void'(q.pop_front());
        if (q.size() < DEPTH) q.push_back(code);
        if (was_full && !do_pop) m_ovf = 1'b1;
        else if (do_clr)         m_ovf = 1'b0;
        cyc(30);
        pressed = 16'h0000;
        cyc(4);
        wait_idle("timed");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int code;
        int npop;
        rst       = 1'b1;
        key_ready = 1'b0;
        clear_ovf = 1'b0;
        pressed   = 16'h0000;
        m_ovf     = 1'b0;
        pressed[4] = 1'b1;
        cyc(2);
        check("rst_col", col, 4'b1111);
        check("rst_valid", key_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_code", key_code, 0);
        rst = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("post_rst_scan", busy, 1);
        cyc(40);
        pressed = 16'h0000;
        cyc(4);
        wait_idle("post_rst");
        model_push(4);
        check_state("post_rst");
        pop_check("post_rst");

        // single press of code 9 with latency bound
        pressed = 16'h0000;
        pressed[9] = 1'b1;
        n = 0;
        while (key_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("single_latency_ok", (n <= LAT_BOUND), 1);
        if (n < 40) cyc(40 - n);
        pressed = 16'h0000;
        cyc(4);
        wait_idle("single");
        model_push(9);
        check_state("single");
        pop_check("single");
        check_state("single_empty");

        // bouncing contact never stays stable for D cycles
        for (int i = 0; i < 20; i++) begin
            pressed = 16'h0000;
            pressed[9] = (i % 2 == 0);
            cyc(2);
        end
        pressed = 16'h0000;
        cyc(4);
        wait_idle("bounce");
        check_state("bounce");
        press_model(3);
        check_state("clean3");
        pop_check("clean3");

        // multi-key in column 0: rows 0 and 2
        pressed = 16'h0000;
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        cyc(30);
        check("multi_col", col, 4'b1111);
        check("multi_busy", busy, 1);
        check("multi_valid", key_valid, 0);
        pressed = 16'h0000;
        cyc(3);
        check("multi_release_wait", busy, 1);
        cyc(10);
        check("multi_done", busy, 0);
        check_state("multi");

        // overflow with no consumer
        press_model(0);
        press_model(5);
        press_model(10);
        press_model(15);
        press_model(6);
        check_state("ovf_set");
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        m_ovf = 1'b0;
        check_state("ovf_clear");
        press_timed(12, 1'b0, 1'b1);
        check_state("ovf_set_wins");
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        m_ovf = 1'b0;
        for (int i = 0; i < 4; i++) pop_check("ovf_drain");
        check_state("ovf_drained");

        // full queue with a pop during the write cycle
        press_model(1);
        press_model(2);
        press_model(7);
        press_model(14);
        press_timed(11, 1'b1, 1'b0);
        check_state("simul");
        for (int i = 0; i < 4; i++) pop_check("simul_drain");
        check_state("simul_drained");

        key_ready = 1'b1;
        cyc(2);
        key_ready = 1'b0;
        check_state("ready_when_empty");

        // randomized presses and partial drains
        for (int it = 0; it < 8; it++) begin
            code = $urandom_range(0, 15);
            press_model(code);
            check_state("rand_press");
            if ($urandom_range(0, 2) == 0) begin
                clear_ovf = 1'b1;
                @(negedge clk);
                clear_ovf = 1'b0;
                m_ovf = 1'b0;
            end
            npop = $urandom_range(0, q.size());
            for (int k = 0; k < npop; k++) pop_check("rand_pop");
            check_state("rand_after");
        end

        // reset mid-operation with a key still held
        press_model(13);
        pressed = 16'h0000;
        pressed[13] = 1'b1;
        cyc(10);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", key_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_col", col, 4'b1111);
        check("midrst_ovf", overflow, 0);
        check("midrst_code", key_code, 0);
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        cyc(40);
        pressed = 16'h0000;
        cyc(4);
        wait_idle("midrst");
        model_push(13);
        check_state("midrst_redetect");
        pop_check("midrst_redetect");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
